// File: rtl/lp_tree_serializer_pkg.sv
// Shared constants for the 16-bit tree serializer: frame width, slot counter
// width and the slot-to-frame-bit ordering table.
package lp_tree_serializer_pkg;

  localparam int N     = 16;
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] slot_t;

  localparam slot_t LOAD_SLOT = 4'd15;

  // ORDER[slot] is the PAR_IN bit index transmitted in that slot.
  localparam slot_t ORDER [N] = '{
    4'd10, 4'd0,  4'd13, 4'd6,
    4'd8,  4'd3,  4'd14, 4'd4,
    4'd11, 4'd1,  4'd12, 4'd7,
    4'd9,  4'd2,  4'd15, 4'd5
  };

endpackage

// File: rtl/lp_tree_serializer_mux2.sv
// Single 2:1 mux cell used at every node of the serializer tree.
module lp_tree_mux2
  import lp_tree_serializer_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/lp_tree_serializer.sv
// Free-running 16-slot parallel-to-serial converter; frame bits reach SERIAL_OUT
// through a 4-level mux tree whose leaves are wired in ORDER sequence.
module lp_tree_serializer
  import lp_tree_serializer_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] PAR_IN,
  output logic         SERIAL_OUT,
  inout  wire          VPWR,
  inout  wire          VGND
);

  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     frame;
  logic [7:0]       leaf;
  logic [3:0]       lvl2;
  logic [1:0]       lvl3;
  logic             tree_out;

  // Supply pins carry no logic; folded here only so they are referenced.
  wire unused_supply = VPWR ^ VGND;

  // Leaves switch on the counter MSB, so they toggle only twice per frame.
  for (genvar k = 0; k < 8; k++) begin : g_leaf
    lp_tree_mux2 u_mux (
      .a   (frame[ORDER[k]]),
      .b   (frame[ORDER[k+8]]),
      .sel (cnt[3]),
      .y   (leaf[k])
    );
  end

  for (genvar m = 0; m < 4; m++) begin : g_lvl2
    lp_tree_mux2 u_mux (
      .a   (leaf[m]),
      .b   (leaf[m+4]),
      .sel (cnt[2]),
      .y   (lvl2[m])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_lvl3
    lp_tree_mux2 u_mux (
      .a   (lvl2[p]),
      .b   (lvl2[p+2]),
      .sel (cnt[1]),
      .y   (lvl3[p])
    );
  end

  lp_tree_mux2 u_root (
    .a   (lvl3[0]),
    .b   (lvl3[1]),
    .sel (cnt[0]),
    .y   (tree_out)
  );

  // Slot counter, frame capture on the last slot, and the output flop.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= {CNT_W{1'b0}};
      frame      <= {N{1'b0}};
      SERIAL_OUT <= 1'b0;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      SERIAL_OUT <= tree_out;
      if (cnt == LOAD_SLOT) begin
        frame <= PAR_IN;
      end
    end
  end

endmodule

// File: tb/tb_lp_tree_serializer.sv
// Scoreboard bench: stimulus queues the expected serial stream per frame and a
// negedge monitor compares every output bit against it.
module tb_lp_tree_serializer;

  localparam int ORDER_TB [16] = '{10, 0, 13, 6, 8, 3, 14, 4, 11, 1, 12, 7, 9, 2, 15, 5};

  logic        clk;
  logic        rst;
  logic [15:0] par_in;
  logic        serial_out;
  wire         vpwr;
  wire         vgnd;

  assign vpwr = 1'b1;
  assign vgnd = 1'b0;

  logic exp_q [$];
  logic mon_en;
  int   n_checks;
  int   n_fail;

  lp_tree_serializer dut (
    .CLK        (clk),
    .RESET      (rst),
    .PAR_IN     (par_in),
    .SERIAL_OUT (serial_out),
    .VPWR       (vpwr),
    .VGND       (vgnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: one expected bit per clock once the stream is live.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL serial_stream: got %0b, required an entry but queue empty", serial_out);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (serial_out !== e) begin
          n_fail++;
          $display("FAIL serial_stream @%0t: got %0b required %0b", $time, serial_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] permute(input logic [15:0] w);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = w[ORDER_TB[j]];
    return r;
  endfunction

  // stream bit j is the value expected in slot j
  task automatic push_slots(input logic [15:0] stream);
    for (int j = 0; j < 16; j++) exp_q.push_back(stream[j]);
  endtask

  // One 16-edge window: noise on PAR_IN except at the load edge.
  task automatic send_frame_exp(input logic [15:0] w, input logic [15:0] noise,
                                input logic [15:0] stream);
    push_slots(stream);
    for (int e = 1; e <= 16; e++) begin
      par_in = (e == 16) ? w : noise;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input logic [15:0] noise);
    send_frame_exp(w, noise, permute(w));
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    push_slots(16'h0000);
    mon_en = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    par_in   = 16'hFFFF;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_serial_out", {31'd0, serial_out}, 32'd0);
    end

    // All-ones held through release: 16 zero bits, then ones.
    release_reset();
    send_frame_exp(16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_frame_exp(16'hFFFF, 16'hFFFF, 16'hFFFF);

    send_frame_exp(16'h0400, 16'hFBFF, 16'h0001);
    send_frame_exp(16'h0020, 16'hFFDF, 16'h8000);

    for (int i = 0; i < 16; i++) begin
      w = 16'h0001 << i;
      send_frame(w, ~w);
    end

    send_frame_exp(16'hAAAA, 16'hAAAA, 16'hDB24);
    send_frame_exp(16'h5555, 16'h5555, 16'h24DB);
    send_frame_exp(16'hAAAA, 16'hAAAA, 16'hDB24);
    send_frame_exp(16'h5555, 16'h5555, 16'h24DB);

    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      send_frame(w, 16'($urandom));
    end

    // Mid-frame reset while an all-ones frame is being shifted out.
    send_frame_exp(16'hFFFF, 16'h0000, 16'hFFFF);
    par_in = 16'h0000;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("pre_reset_serial_out", {31'd0, serial_out}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_serial_out", {31'd0, serial_out}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("held_reset_serial_out", {31'd0, serial_out}, 32'd0);
    par_in = 16'hFFFF;
    release_reset();
    send_frame_exp(16'h5555, 16'hFFFF, 16'h24DB);
    send_frame(16'h8421, 16'h0000);

    for (int e = 0; e < 16; e++) begin
      par_in = 16'h0000;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
